// File: rtl/alu_issue_queue.sv
// Issue queue for a combinational 32-bit ALU: command FIFO, head drive onto the ALU, registered result stage.
// Optional ALU_ISSUE_STATS_EN adds saturating stat_ops/stat_ovf counters.
module alu_issue_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
`ifdef ALU_ISSUE_STATS_EN
  output logic [15:0]                stat_ops,
  output logic [15:0]                stat_ovf,
`endif
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [2:0]                 in_ctrl,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [2:0]                 alu_ctrl,
  input  logic [WIDTH-1:0]           alu_result,
  input  logic                       alu_zero,
  input  logic                       alu_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic                       out_zero,
  output logic                       out_overflow,
  output logic                       out_illegal,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [2:0]       mem_c_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q;
  logic             zero_q, ovf_q, ill_q;

  logic push, load, has_head, legal, cap_ovf;

  assign has_head = (count_q != '0);
  assign in_ready = rst_n && (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign load     = has_head && ((state_q == S_EMPTY) || out_ready);

  assign alu_a    = has_head ? mem_a_q[rd_ptr_q] : '0;
  assign alu_b    = has_head ? mem_b_q[rd_ptr_q] : '0;
  assign alu_ctrl = has_head ? mem_c_q[rd_ptr_q] : 3'b000;

  assign legal    = (alu_ctrl inside {3'b000, 3'b001, 3'b010, 3'b011, 3'b101});
  // ALU overflow is only meaningful for add/sub; mask it for every other op
  assign cap_ovf  = legal && (alu_ctrl == 3'b000 || alu_ctrl == 3'b001) && alu_overflow;

  always_comb begin
    count_d = count_q;
    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= in_a;
      mem_b_q[wr_ptr_q] <= in_b;
      mem_c_q[wr_ptr_q] <= in_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Output stage FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Output stage FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (load) state_d = S_FULL;
      S_FULL:  if (load) state_d = S_FULL;
               else if (out_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // Output stage FSM: outputs
  always_comb begin
    out_valid = (state_q == S_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else if (load) begin
      res_q  <= legal ? alu_result : '0;
      zero_q <= legal ? alu_zero : 1'b1;
      ovf_q  <= cap_ovf;
      ill_q  <= !legal;
    end
  end

  assign out_result   = res_q;
  assign out_zero     = zero_q;
  assign out_overflow = ovf_q;
  assign out_illegal  = ill_q;
  assign count        = count_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops_q, stat_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else if (load) begin
      if (stat_ops_q != 16'hFFFF)            stat_ops_q <= stat_ops_q + 16'd1;
      if (cap_ovf && stat_ovf_q != 16'hFFFF) stat_ovf_q <= stat_ovf_q + 16'd1;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue (WIDTH=32, DEPTH=4) with a behavioural ALU attached.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [2:0]  in_ctrl = '0;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero, alu_overflow;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_zero, out_overflow, out_illegal;
  logic [2:0]  count;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops, stat_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        ill;
  } exp_t;
  exp_t exp_q[$];

  alu_issue_queue #(.WIDTH(32), .DEPTH(4)) dut (
`ifdef ALU_ISSUE_STATS_EN
    .stat_ops(stat_ops), .stat_ovf(stat_ovf),
`endif
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_overflow(out_overflow), .out_illegal(out_illegal),
    .count(count)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; overflow is raised from the adder for every opcode so masking is visible,
  // and illegal opcodes return junk that the issue stage must override
  always_comb begin
    logic [31:0] s;
    s = (alu_ctrl == 3'b001) ? alu_a - alu_b : alu_a + alu_b;
    alu_result = 32'h0000_1234;
    case (alu_ctrl)
      3'b000, 3'b001: alu_result = s;
      3'b010:         alu_result = alu_a & alu_b;
      3'b011:         alu_result = alu_a | alu_b;
      3'b101:         alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default:        alu_result = 32'h0000_1234;
    endcase
    alu_zero = (alu_result == 32'd0);
    if (alu_ctrl == 3'b001) alu_overflow = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
    else                    alu_overflow = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e, g;
      n_vec++;
      g = '{out_result, out_zero, out_overflow, out_illegal};
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result got res=%h z=%b o=%b ill=%b want none", out_result,
                 out_zero, out_overflow, out_illegal);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          n_err++;
          $display("FAIL result got res=%h z=%b o=%b ill=%b want res=%h z=%b o=%b ill=%b",
                   g.res, g.z, g.o, g.ill, e.res, e.z, e.o, e.ill);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge
  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                          input bit chk, input logic [31:0] er, input bit ez, input bit eo,
                          input bit ei);
    int t = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_ctrl = c;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout got in_ready=0 want 1");
    end else if (chk) exp_q.push_back('{er, ez, eo, ei});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_count"}, 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    check("rst_out_flags", {out_result[30:0], out_zero}, 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // add with latency check
    in_valid = 1'b1; in_a = 32'd5; in_b = 32'd3; in_ctrl = 3'b000;
    exp_q.push_back('{32'd8, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_valid_n", 32'(out_valid), 32'd0);
    check("lat_count_n", 32'(count), 32'd1);
    check("lat_alu_a", alu_a, 32'd5);
    @(posedge clk); #1;
    check("lat_valid_n1", 32'(out_valid), 32'd1);
    drain("add");

    push_cmd(32'd7, 32'd7, 3'b001, 1, 32'd0, 1, 0, 0);
    push_cmd(32'h7FFF_FFFF, 32'd1, 3'b000, 1, 32'h8000_0000, 0, 1, 0);
    push_cmd(32'h7FFF_FFFF, 32'd1, 3'b010, 1, 32'd1, 0, 0, 0);
    push_cmd(32'h8000_0000, 32'd1, 3'b001, 1, 32'h7FFF_FFFF, 0, 1, 0);
    push_cmd(32'h0000_00F0, 32'h0000_000F, 3'b011, 1, 32'h0000_00FF, 0, 0, 0);
    push_cmd(32'hFFFF_FFFD, 32'd5, 3'b101, 1, 32'd1, 0, 0, 0);
    push_cmd(32'd9, 32'd2, 3'b110, 1, 32'd0, 1, 0, 1);
    push_cmd(32'h7FFF_FFFF, 32'd1, 3'b100, 1, 32'd0, 1, 0, 1);
    push_cmd(32'd1, 32'd1, 3'b111, 1, 32'd0, 1, 0, 1);
    push_cmd(32'd4, 32'd4, 3'b000, 1, 32'd8, 0, 0, 0);
    drain("ops");

    // backpressure: 6 back-to-back attempts, DEPTH+1 fit
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = 32'(10 * i); in_b = 32'(i); in_ctrl = 3'b000;
      @(negedge clk);
      if (in_ready) begin
        acc++;
        exp_q.push_back('{32'(11 * i), (i == 0), 1'b0, 1'b0});
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_count", 32'(count), 32'd4);
    @(posedge clk); #1;
    check("bp_hold_result", out_result, 32'd0);
    check("bp_hold_zero", 32'(out_zero), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_streaming", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    check("bp_empty_after", 32'(out_valid), 32'd0);
    drain("bp");

    // reset mid-operation
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(32'(i + 1), 32'd3, 3'b010, 0, 32'd0, 0, 0, 0);
    check("mid_count", 32'(count), 32'd3);
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_alu_ctrl", 32'(alu_ctrl), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("mid_no_pulse", 32'(out_valid), 32'd0);

`ifdef ALU_ISSUE_STATS_EN
    push_cmd(32'd1, 32'd1, 3'b000, 1, 32'd2, 0, 0, 0);
    push_cmd(32'h7FFF_FFFF, 32'd1, 3'b000, 1, 32'h8000_0000, 0, 1, 0);
    push_cmd(32'd5, 32'd2, 3'b001, 1, 32'd3, 0, 0, 0);
    drain("stats");
    check("stat_ops", 32'(stat_ops), 32'd3);
    check("stat_ovf", 32'(stat_ovf), 32'd1);
`endif

    push_cmd(32'd100, 32'd1, 3'b001, 1, 32'd99, 0, 0, 0);
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
